ctrl_decode: RTL and testbench

- MIPS instruction decoder used by every pipeline stage (ID, EX, MEM, WB): each stage instantiates one copy on its own instruction register.
- Turns a 32-bit instruction word into one-hot per-instruction flags, from which the stage derives ALUOp, ALUSrc, MDUOp, branch, forwarding and write-back controls.
- Decode is purely combinational.
- Adds a reserved-instruction (RI) detector with a sticky registered flag for exception/debug use.

---
 rtl/ctrl_decode.sv | 158 +++++++++++++++
 tb/tb_ctrl_decode.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode.sv
// MIPS instruction decoder: 32-bit word -> one-hot per-instruction flags plus a reserved-instruction flag.
// Latency: flags and ri are combinational in I; ri_sticky is registered and updates on the clock edge after ri.
// Backpressure: none; the decoder accepts a new word every cycle.
module ctrl_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] I,
    output logic        R,
    output logic        lb,
    output logic        lbu,
    output logic        lh,
    output logic        lhu,
    output logic        lw,
    output logic        sb,
    output logic        sh,
    output logic        sw,
    output logic        add,
    output logic        addu,
    output logic        sub,
    output logic        subu,
    output logic        slt,
    output logic        sltu,
    output logic        sll,
    output logic        srl,
    output logic        sra,
    output logic        sllv,
    output logic        srlv,
    output logic        srav,
    output logic        and_,
    output logic        or_,
    output logic        xor_,
    output logic        nor_,
    output logic        mult,
    output logic        multu,
    output logic        div,
    output logic        divu,
    output logic        mfhi,
    output logic        mflo,
    output logic        mthi,
    output logic        mtlo,
    output logic        addi,
    output logic        addiu,
    output logic        andi,
    output logic        ori,
    output logic        xori,
    output logic        lui,
    output logic        slti,
    output logic        sltiu,
    output logic        beq,
    output logic        bne,
    output logic        blez,
    output logic        bgtz,
    output logic        bltz,
    output logic        bgez,
    output logic        j,
    output logic        jal,
    output logic        jalr,
    output logic        jr,
    output logic        eret,
    output logic        mfc0,
    output logic        mtc0,
    output logic        ri,
    output logic        ri_sticky
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       regimm;
    logic       cop0;

    assign op     = I[31:26];
    assign rs     = I[25:21];
    assign rt     = I[20:16];
    assign funct  = I[5:0];
    assign regimm = (op == 6'h01);
    assign cop0   = (op == 6'h10);

    // R is the SPECIAL-opcode indicator; it stays high even for unknown funct codes.
    assign R = (op == 6'h00);

    assign sll   = R && (funct == 6'h00);
    assign srl   = R && (funct == 6'h02);
    assign sra   = R && (funct == 6'h03);
    assign sllv  = R && (funct == 6'h04);
    assign srlv  = R && (funct == 6'h06);
    assign srav  = R && (funct == 6'h07);
    assign jr    = R && (funct == 6'h08);
    assign jalr  = R && (funct == 6'h09);
    assign mfhi  = R && (funct == 6'h10);
    assign mthi  = R && (funct == 6'h11);
    assign mflo  = R && (funct == 6'h12);
    assign mtlo  = R && (funct == 6'h13);
    assign mult  = R && (funct == 6'h18);
    assign multu = R && (funct == 6'h19);
    assign div   = R && (funct == 6'h1A);
    assign divu  = R && (funct == 6'h1B);
    assign add   = R && (funct == 6'h20);
    assign addu  = R && (funct == 6'h21);
    assign sub   = R && (funct == 6'h22);
    assign subu  = R && (funct == 6'h23);
    assign and_  = R && (funct == 6'h24);
    assign or_   = R && (funct == 6'h25);
    assign xor_  = R && (funct == 6'h26);
    assign nor_  = R && (funct == 6'h27);
    assign slt   = R && (funct == 6'h2A);
    assign sltu  = R && (funct == 6'h2B);

    assign j     = (op == 6'h02);
    assign jal   = (op == 6'h03);
    assign beq   = (op == 6'h04);
    assign bne   = (op == 6'h05);
    assign blez  = (op == 6'h06);
    assign bgtz  = (op == 6'h07);
    assign addi  = (op == 6'h08);
    assign addiu = (op == 6'h09);
    assign slti  = (op == 6'h0A);
    assign sltiu = (op == 6'h0B);
    assign andi  = (op == 6'h0C);
    assign ori   = (op == 6'h0D);
    assign xori  = (op == 6'h0E);
    assign lui   = (op == 6'h0F);
    assign lb    = (op == 6'h20);
    assign lh    = (op == 6'h21);
    assign lw    = (op == 6'h23);
    assign lbu   = (op == 6'h24);
    assign lhu   = (op == 6'h25);
    assign sb    = (op == 6'h28);
    assign sh    = (op == 6'h29);
    assign sw    = (op == 6'h2B);

    assign bltz  = regimm && (rt == 5'd0);
    assign bgez  = regimm && (rt == 5'd1);

    // eret is matched on the full word; its rs field (0x10) never collides with mfc0/mtc0.
    assign mfc0  = cop0 && (rs == 5'd0);
    assign mtc0  = cop0 && (rs == 5'd4);
    assign eret  = (I == 32'h4200_0018);

    assign ri = ~(lb | lbu | lh | lhu | lw | sb | sh | sw |
                  add | addu | sub | subu | slt | sltu |
                  sll | srl | sra | sllv | srlv | srav |
                  and_ | or_ | xor_ | nor_ |
                  mult | multu | div | divu | mfhi | mflo | mthi | mtlo |
                  addi | addiu | andi | ori | xori | lui | slti | sltiu |
                  beq | bne | blez | bgtz | bltz | bgez | j | jal | jalr | jr |
                  eret | mfc0 | mtc0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ri_sticky <= 1'b0;
        end else if (ri) begin
            ri_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_decode.sv
// Directed decode vectors with a queue-based scoreboard; the monitor pops one expectation per cycle.
module tb_ctrl_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] I = 32'h0;
    logic        R;
    logic        ri;
    logic        ri_sticky;
    logic [52:0] f;

    always #5 clk = ~clk;

    string names [53] = '{
        "lb", "lbu", "lh", "lhu", "lw", "sb", "sh", "sw",
        "add", "addu", "sub", "subu", "slt", "sltu", "sll", "srl",
        "sra", "sllv", "srlv", "srav", "and_", "or_", "xor_", "nor_",
        "mult", "multu", "div", "divu", "mfhi", "mflo", "mthi", "mtlo",
        "addi", "addiu", "andi", "ori", "xori", "lui", "slti", "sltiu",
        "beq", "bne", "blez", "bgtz", "bltz", "bgez", "j", "jal",
        "jalr", "jr", "eret", "mfc0", "mtc0"};

    ctrl_decode dut (
        .clk(clk), .reset(reset), .I(I), .R(R),
        .lb(f[0]), .lbu(f[1]), .lh(f[2]), .lhu(f[3]), .lw(f[4]), .sb(f[5]), .sh(f[6]), .sw(f[7]),
        .add(f[8]), .addu(f[9]), .sub(f[10]), .subu(f[11]), .slt(f[12]), .sltu(f[13]),
        .sll(f[14]), .srl(f[15]), .sra(f[16]), .sllv(f[17]), .srlv(f[18]), .srav(f[19]),
        .and_(f[20]), .or_(f[21]), .xor_(f[22]), .nor_(f[23]),
        .mult(f[24]), .multu(f[25]), .div(f[26]), .divu(f[27]),
        .mfhi(f[28]), .mflo(f[29]), .mthi(f[30]), .mtlo(f[31]),
        .addi(f[32]), .addiu(f[33]), .andi(f[34]), .ori(f[35]), .xori(f[36]), .lui(f[37]),
        .slti(f[38]), .sltiu(f[39]),
        .beq(f[40]), .bne(f[41]), .blez(f[42]), .bgtz(f[43]), .bltz(f[44]), .bgez(f[45]),
        .j(f[46]), .jal(f[47]), .jalr(f[48]), .jr(f[49]),
        .eret(f[50]), .mfc0(f[51]), .mtc0(f[52]),
        .ri(ri), .ri_sticky(ri_sticky)
    );

    typedef struct packed {
        logic [31:0] i;
        logic [52:0] flags;
        logic        r;
        logic        ri;
        logic        sticky;
    } exp_t;

    exp_t q[$];
    logic mon_vld = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic model_sticky = 1'b0;

    function automatic logic [52:0] onehot(input string n);
        logic [52:0] v;
        v = '0;
        for (int k = 0; k < 53; k++) begin
            if (names[k] == n) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Expected sticky value seen in a cycle reflects the reset/ri of the previous cycle's edge.
    task automatic drive(input logic [31:0] instr, input string n, input logic r_exp,
                         input logic rst = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        I = instr;
        reset = rst;
        e.i = instr;
        e.flags = onehot(n);
        e.r = r_exp;
        e.ri = (e.flags == '0);
        e.sticky = model_sticky;
        q.push_back(e);
        mon_vld = 1'b1;
        if (rst) model_sticky = 1'b0;
        else if (e.ri) model_sticky = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_vld) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL queue_empty: got no expectation, wanted one");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if (f !== e.flags) begin
                    n_fail++;
                    $display("FAIL flags I=%h: got %h, wanted %h", e.i, f, e.flags);
                end
                n_chk++;
                if (R !== e.r) begin
                    n_fail++;
                    $display("FAIL R I=%h: got %b, wanted %b", e.i, R, e.r);
                end
                n_chk++;
                if (ri !== e.ri) begin
                    n_fail++;
                    $display("FAIL ri I=%h: got %b, wanted %b", e.i, ri, e.ri);
                end
                n_chk++;
                if (ri_sticky !== e.sticky) begin
                    n_fail++;
                    $display("FAIL ri_sticky I=%h: got %b, wanted %b", e.i, ri_sticky, e.sticky);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // Spec examples and SPECIAL funct sweep (shamt/rd carry junk)
        drive(32'h0000_0000, "sll", 1);
        drive(32'h012A_4021, "addu", 1);
        drive(32'h012A_40C0, "sll", 1);
        drive(32'h012A_40C2, "srl", 1);
        drive(32'h012A_40C3, "sra", 1);
        drive(32'h012A_40C4, "sllv", 1);
        drive(32'h012A_40C6, "srlv", 1);
        drive(32'h012A_40C7, "srav", 1);
        drive(32'h012A_40C8, "jr", 1);
        drive(32'h012A_40C9, "jalr", 1);
        drive(32'h012A_40D0, "mfhi", 1);
        drive(32'h012A_40D1, "mthi", 1);
        drive(32'h012A_40D2, "mflo", 1);
        drive(32'h012A_40D3, "mtlo", 1);
        drive(32'h012A_40D8, "mult", 1);
        drive(32'h012A_40D9, "multu", 1);
        drive(32'h012A_40DA, "div", 1);
        drive(32'h012A_40DB, "divu", 1);
        drive(32'h012A_40E0, "add", 1);
        drive(32'h012A_40E1, "addu", 1);
        drive(32'h012A_40E2, "sub", 1);
        drive(32'h012A_40E3, "subu", 1);
        drive(32'h012A_40E4, "and_", 1);
        drive(32'h012A_40E5, "or_", 1);
        drive(32'h012A_40E6, "xor_", 1);
        drive(32'h012A_40E7, "nor_", 1);
        drive(32'h012A_40EA, "slt", 1);
        drive(32'h012A_40EB, "sltu", 1);
        drive(32'h0320_F809, "jalr", 1);
        // Non-SPECIAL opcodes with low field 0x1234567
        drive(32'h0923_4567, "j", 0);
        drive(32'h0D23_4567, "jal", 0);
        drive(32'h1123_4567, "beq", 0);
        drive(32'h1523_4567, "bne", 0);
        drive(32'h1923_4567, "blez", 0);
        drive(32'h1D23_4567, "bgtz", 0);
        drive(32'h2123_4567, "addi", 0);
        drive(32'h2523_4567, "addiu", 0);
        drive(32'h2923_4567, "slti", 0);
        drive(32'h2D23_4567, "sltiu", 0);
        drive(32'h3123_4567, "andi", 0);
        drive(32'h3523_4567, "ori", 0);
        drive(32'h3923_4567, "xori", 0);
        drive(32'h3D23_4567, "lui", 0);
        drive(32'h8123_4567, "lb", 0);
        drive(32'h8523_4567, "lh", 0);
        drive(32'h8D23_4567, "lw", 0);
        drive(32'h9123_4567, "lbu", 0);
        drive(32'h9523_4567, "lhu", 0);
        drive(32'hA123_4567, "sb", 0);
        drive(32'hA523_4567, "sh", 0);
        drive(32'hAD23_4567, "sw", 0);
        drive(32'h8D09_0004, "lw", 0);
        drive(32'h3C08_1234, "lui", 0);
        drive(32'h0C00_0C00, "jal", 0);
        // REGIMM and COP0
        drive(32'h0500_0003, "bltz", 0);
        drive(32'h0501_0003, "bgez", 0);
        drive(32'h04E0_FFFF, "bltz", 0);
        drive(32'h4008_6000, "mfc0", 0);
        drive(32'h4088_6000, "mtc0", 0);
        drive(32'h4200_0018, "eret", 0);
        // Reserved encodings: sticky sets after the first, holds through valid words
        drive(32'h0502_0003, "", 0);
        drive(32'h4200_0019, "", 0);
        drive(32'h4028_6000, "", 0);
        drive(32'h0411_0000, "", 0);
        drive(32'h8923_4567, "", 0);
        drive(32'hFC00_0000, "", 0);
        drive(32'h0000_003F, "", 1);
        drive(32'h0000_0001, "", 1);
        drive(32'h012A_4021, "addu", 1);
        drive(32'h8D09_0004, "lw", 0);
        // Reset with an RI word present: reset wins; decode still live during reset
        drive(32'hFC00_0000, "", 0, 1'b1);
        drive(32'h0000_0000, "sll", 1);
        drive(32'h3C08_1234, "lui", 0);
        @(posedge clk);
        #1;
        mon_vld = 1'b0;
        for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending, wanted 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

endmodule
